cmd_word_packer: RTL
====================

// Module: cmd_word_packer
// PURPOSE
//  Downstream of the UDP command receiver. Consumes its 8-bit ETH_CMD AXIS byte stream, validates the payload length
//  and packs bytes big-endian into 32-bit words. Only complete, length-correct frames are re-emitted as a 32-bit AXIS
//  word stream to the motor command decoder. Bad frames are discarded whole; no partial frame ever leaves the block.
// PARAMETERS
//  CMD_BYTES   40   payload bytes per valid command frame; multiple of 4, range 4..1020
//  CMD_WORDS   CMD_BYTES/4   derived localparam; depth of the frame store
//  CNT_W       16   width of the dropped-frame counter
// PORTS
//  CLK_125M         in   1       single clock for the whole block
//  SYS_RST          in   1       synchronous, active-high reset
//  ETH_CMD_TVALID   in   1       input byte valid
//  ETH_CMD_TREADY   out  1       input ready; held 1 outside reset (the source cannot stall)
//  ETH_CMD_TLAST    in   1       frame trailer beat; its byte is not payload
//  ETH_CMD_TDATA    in   8       payload byte
//  ETH_CMD_TUSER    in   32      frame tag; sampled on the first payload beat
//  TRIG_PACK_RST    in   1       pulse: abort the frame being collected and flush the store
//  CMD_WORD_TVALID  out  1       output word valid
//  CMD_WORD_TREADY  in   1       output ready
//  CMD_WORD_TLAST   out  1       high on word CMD_WORDS-1
//  CMD_WORD_TDATA   out  32      packed word; first byte received in [31:24]
//  CMD_WORD_TUSER   out  32      tag of the frame; constant for the whole frame
//  CMD_FRAME_ERR    out  1       1-cycle pulse when a frame is rejected for length
//  CMD_DROP_CNT     out  CNT_W   frames dropped because the store was busy; saturates at all-ones
// BEHAVIOUR
//  Reset values: all outputs 0, except ETH_CMD_TREADY = 0 during reset and 1 otherwise.
//  Reset state is IDLE; byte, word and read counters clear to 0.
//  Input beat = TVALID & TREADY. Payload beat = input beat with TLAST = 0. Trailer beat = input beat with TLAST = 1.
//  FSM: IDLE, COLLECT, DISCARD, DRAIN.
//   IDLE     payload beat: store the byte, latch TUSER, set byte_cnt = 1, go to COLLECT.
//            Lone trailer beat: pulse CMD_FRAME_ERR, stay in IDLE.
//   COLLECT  payload beat with byte_cnt < CMD_BYTES: shift the byte into the pack register and increment byte_cnt.
//            Each 4th byte writes the pack register to mem[byte_cnt/4].
//            Payload beat with byte_cnt == CMD_BYTES (overrun): go to DISCARD.
//            Trailer beat with byte_cnt == CMD_BYTES: go to DRAIN with rd_idx = 0.
//            Trailer beat with any other count: pulse CMD_FRAME_ERR, go to IDLE.
//   DISCARD  ignore payload beats. On the trailer beat, pulse CMD_FRAME_ERR and go to IDLE.
//   DRAIN    CMD_WORD_TVALID = 1 and CMD_WORD_TDATA = mem[rd_idx], both registered.
//            On output handshake, rd_idx++. The handshake on rd_idx = CMD_WORDS-1 (TLAST = 1) goes to IDLE,
//            and TVALID drops in the next cycle.
//            Input beats arriving in DRAIN are dropped whole. The first payload beat of such a frame increments
//            CMD_DROP_CNT once (saturating); remaining beats through TLAST are ignored.
//            If that frame's trailer beat has not arrived by DRAIN exit, go to DISCARD instead of IDLE.
//            Dropping a frame never pulses CMD_FRAME_ERR.
//  Latency: the first output word is valid on the cycle after the trailer beat. With TREADY held 1, the frame
//   drains in CMD_WORDS cycles.
//  Output rule: TDATA, TUSER and TLAST stay stable while TVALID = 1 and TREADY = 0.
//  TRIG_PACK_RST in COLLECT or DISCARD: go to IDLE and clear the counters, with no FRAME_ERR pulse.
//   If the pulse coincides with a payload beat, that beat is discarded.
//   In DRAIN, TRIG_PACK_RST is ignored, so an accepted frame always completes.
//  Simultaneous events: a trailer beat and TRIG_PACK_RST in the same cycle -> TRIG_PACK_RST wins.
//  SYS_RST in any state, including mid-DRAIN: outputs and FSM return to reset values on the next edge.
//   Store contents are not cleared.
// STRUCTURE
//  Shared package/header (same place as the ETH_RX constants): CMD_BYTES default, FSM state encodings,
//   and the big-endian packing order.
//  One natural sub-module: cmd_word_store. It holds the CMD_WORDS x 32 register array with one write port and one
//   registered read port (distributed RAM). The FSM, counters and packing stay in this module.
// TESTING
//  1. Bytes 0x00..0x27, then a trailer beat, with TREADY = 1 -> 10 words, 0x00010203 .. 0x24252627, on consecutive
//     cycles starting 1 cycle after the trailer; TLAST only on 0x24252627; TUSER equals the tag from the first beat.
//  2. 39 payload bytes + trailer -> CMD_FRAME_ERR pulse, no output. 41 bytes + trailer -> a single FRAME_ERR pulse
//     on the trailer, no output.
//  3. Frame 1 as in test 1 with TREADY toggling 1,0,0,1 -> words stable while stalled, all 10 words delivered in
//     order, nothing duplicated.
//  4. Frame 2 starts while frame 1 is draining -> CMD_DROP_CNT = 1, no FRAME_ERR, frame 2 absent from the output.
//     Frame 3 sent afterwards is delivered intact.
//  5. TRIG_PACK_RST after 20 payload bytes, then a full frame of 0xA0..0xC7 -> only the second frame is output,
//     first word 0xA0A1A2A3. SYS_RST after 3 output words -> TVALID = 0 on the next cycle, FSM in IDLE.
//  6. DROP_CNT saturation (CNT_W = 2 build): 5 overlapping drops -> CMD_DROP_CNT holds 3.

Source files
------------

// File: rtl/cmd_word_packer_pkg.sv
// Shared constants for the ETH command path: default frame size, packer FSM states
// and the big-endian byte packing order.
package cmd_word_packer_pkg;

  localparam int CMD_BYTES_DEF = 40;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2,
    ST_DRAIN   = 2'd3
  } pack_state_e;

  // The first byte of a word ends up in [31:24]: older bytes shift toward the MSB.
  function automatic logic [31:0] pack_be(input logic [23:0] older, input logic [7:0] b);
    return {older, b};
  endfunction

endpackage

// File: rtl/cmd_word_store.sv
// Frame store: WORDS x 32 register array, one write port, one registered read port.
module cmd_word_store #(
  parameter int WORDS = 10,
  parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_d, rdata_q;

  // Contents survive reset; only the read register returns to zero.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cmd_word_packer.sv
// Validates ETH_CMD byte frames and re-emits only complete, length-correct frames
// as big-endian 32-bit words; bad or colliding frames are discarded whole.
module cmd_word_packer
  import cmd_word_packer_pkg::*;
#(
  parameter int CMD_BYTES = CMD_BYTES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             CLK_125M,
  input  logic             SYS_RST,
  input  logic             ETH_CMD_TVALID,
  output logic             ETH_CMD_TREADY,
  input  logic             ETH_CMD_TLAST,
  input  logic [7:0]       ETH_CMD_TDATA,
  input  logic [31:0]      ETH_CMD_TUSER,
  input  logic             TRIG_PACK_RST,
  output logic             CMD_WORD_TVALID,
  input  logic             CMD_WORD_TREADY,
  output logic             CMD_WORD_TLAST,
  output logic [31:0]      CMD_WORD_TDATA,
  output logic [31:0]      CMD_WORD_TUSER,
  output logic             CMD_FRAME_ERR,
  output logic [CNT_W-1:0] CMD_DROP_CNT
);

  localparam int CMD_WORDS = CMD_BYTES / 4;
  localparam int AW        = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
  localparam int BCW       = $clog2(CMD_BYTES + 1);
  localparam logic [BCW-1:0] FULL_CNT = BCW'(CMD_BYTES);
  localparam logic [AW-1:0]  LAST_IDX = AW'(CMD_WORDS - 1);

  pack_state_e      state_d, state_q;
  logic [BCW-1:0]   byte_cnt_d, byte_cnt_q;
  logic [23:0]      pack_d, pack_q;
  logic [AW-1:0]    rd_idx_d, rd_idx_q, rd_nxt;
  logic [31:0]      tag_d, tag_q;
  logic             vld_d, vld_q;
  logic             last_d, last_q;
  logic             err_d, err_q;
  logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;
  logic             drop_act_d, drop_act_q;

  logic             in_beat, pay_beat, trl_beat, out_hs;
  logic             st_we;
  logic [AW-1:0]    st_waddr;
  logic [31:0]      st_wdata, st_rdata;

  assign ETH_CMD_TREADY = ~SYS_RST;
  assign in_beat  = ETH_CMD_TVALID & ETH_CMD_TREADY;
  assign pay_beat = in_beat & ~ETH_CMD_TLAST;
  assign trl_beat = in_beat &  ETH_CMD_TLAST;
  assign out_hs   = vld_q & CMD_WORD_TREADY;
  assign rd_nxt   = rd_idx_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    rd_idx_d   = rd_idx_q;
    tag_d      = tag_q;
    vld_d      = vld_q;
    last_d     = last_q;
    err_d      = 1'b0;
    drop_cnt_d = drop_cnt_q;
    drop_act_d = drop_act_q;
    st_we      = 1'b0;
    st_waddr   = byte_cnt_q[AW+1:2];
    st_wdata   = pack_be(pack_q, ETH_CMD_TDATA);

    unique case (state_q)
      ST_IDLE: begin
        // A flush pulse also swallows any beat arriving with it.
        if (TRIG_PACK_RST) begin
          byte_cnt_d = '0;
          rd_idx_d   = '0;
        end else if (pay_beat) begin
          pack_d     = {16'h0, ETH_CMD_TDATA};
          tag_d      = ETH_CMD_TUSER;
          byte_cnt_d = BCW'(1);
          state_d    = ST_COLLECT;
        end else if (trl_beat) begin
          err_d = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (TRIG_PACK_RST) begin
          byte_cnt_d = '0;
          rd_idx_d   = '0;
          state_d    = ST_IDLE;
        end else if (pay_beat) begin
          if (byte_cnt_q == FULL_CNT) begin
            byte_cnt_d = '0;
            state_d    = ST_DISCARD;
          end else begin
            pack_d     = st_wdata[23:0];
            byte_cnt_d = byte_cnt_q + BCW'(1);
            st_we      = (byte_cnt_q[1:0] == 2'd3);
          end
        end else if (trl_beat) begin
          byte_cnt_d = '0;
          if (byte_cnt_q == FULL_CNT) begin
            rd_idx_d = '0;
            vld_d    = 1'b1;
            last_d   = (LAST_IDX == '0);
            state_d  = ST_DRAIN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_DISCARD: begin
        // drop_act_q marks a frame that collided with a drain: it is counted, not an error.
        if (TRIG_PACK_RST) begin
          byte_cnt_d = '0;
          rd_idx_d   = '0;
          drop_act_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (trl_beat) begin
          err_d      = ~drop_act_q;
          drop_act_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (pay_beat && !drop_act_q) begin
          drop_act_d = 1'b1;
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (trl_beat) drop_act_d = 1'b0;

        if (out_hs) begin
          if (rd_idx_q == LAST_IDX) begin
            vld_d    = 1'b0;
            last_d   = 1'b0;
            rd_idx_d = '0;
            state_d  = drop_act_d ? ST_DISCARD : ST_IDLE;
          end else begin
            rd_idx_d = rd_nxt;
            last_d   = (rd_nxt == LAST_IDX);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_125M) begin
    if (SYS_RST) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      rd_idx_q   <= '0;
      tag_q      <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
      drop_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
      rd_idx_q   <= rd_idx_d;
      tag_q      <= tag_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
      drop_act_q <= drop_act_d;
    end
  end

  // Read address follows the next index so the registered word lines up with vld_q.
  cmd_word_store #(
    .WORDS (CMD_WORDS),
    .AW    (AW)
  ) u_store (
    .clk   (CLK_125M),
    .rst   (SYS_RST),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (rd_idx_d),
    .rdata (st_rdata)
  );

  assign CMD_WORD_TVALID = vld_q;
  assign CMD_WORD_TLAST  = last_q;
  assign CMD_WORD_TDATA  = st_rdata;
  assign CMD_WORD_TUSER  = tag_q;
  assign CMD_FRAME_ERR   = err_q;
  assign CMD_DROP_CNT    = drop_cnt_q;

endmodule
